// File: rtl/axil_ram_master_if.sv
// rtl/axil_ram_master_if.sv - AXI4-Lite bus bundle between the RAM master and one RAM slave port
interface axil_ram_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_ram_master.sv
// rtl/axil_ram_master.sv - AXI4-Lite initiator turning one cmd request into one RAM transaction
// Define AXIL_RAM_MASTER_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYCLES.
module axil_ram_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  a_clk,
   input  logic                  a_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  busy,
   axil_ram_master_if.master     m_axil
);
   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [2:0]            prot_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            resp_q;
   logic                  aw_done, w_done;
   logic                  aw_hs, w_hs;

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // cmd_ready is gated by reset so nothing looks acceptable while the block is held in reset
   assign cmd_ready = (state == IDLE) && a_rst;
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RSP);
   assign rsp_write = write_q;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

   assign m_axil.awaddr  = addr_q;
   assign m_axil.awprot  = prot_q;
   assign m_axil.awvalid = (state == WRITE) && !aw_done;
   assign m_axil.wdata   = wdata_q;
   assign m_axil.wstrb   = wstrb_q;
   assign m_axil.wvalid  = (state == WRITE) && !w_done;
   assign m_axil.bready  = (state == WRESP);
   assign m_axil.araddr  = addr_q;
   assign m_axil.arprot  = prot_q;
   assign m_axil.arvalid = (state == READ);
   assign m_axil.rready  = (state == RDATA);

   assign aw_hs = m_axil.awvalid && m_axil.awready;
   assign w_hs  = m_axil.wvalid && m_axil.wready;

`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] tmo_cnt;
   logic             in_txn;
   logic             tmo_expire;

   assign in_txn = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RDATA);

   always_ff @(posedge a_clk or negedge a_rst) begin
      if (!a_rst) begin
         tmo_cnt <= '0;
      end else if (in_txn) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`endif

   always_comb begin
      state_next = state;
`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
      tmo_expire = 1'b0;
`endif
      case (state)
         IDLE:    if (cmd_valid) state_next = cmd_write ? WRITE : READ;
         WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
         WRESP:   if (m_axil.bvalid) state_next = RSP;
         READ:    if (m_axil.arready) state_next = RDATA;
         RDATA:   if (m_axil.rvalid) state_next = RSP;
         RSP:     if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
      // A phase finishing on the last allowed cycle still wins over the watchdog
      if (in_txn && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && (state_next == state)) begin
         tmo_expire = 1'b1;
         state_next = RSP;
      end
`endif
   end

   always_ff @(posedge a_clk or negedge a_rst) begin
      if (!a_rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         prot_q  <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         resp_q  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  prot_q  <= cmd_prot;
                  write_q <= cmd_write;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            WRITE: begin
               aw_done <= aw_done || aw_hs;
               w_done  <= w_done || w_hs;
            end
            WRESP: begin
               if (m_axil.bvalid) begin
                  resp_q  <= m_axil.bresp;
                  rdata_q <= '0;
               end
            end
            RDATA: begin
               if (m_axil.rvalid) begin
                  resp_q  <= m_axil.rresp;
                  rdata_q <= m_axil.rdata;
               end
            end
            default: ;
         endcase
`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
         if (tmo_expire) begin
            resp_q  <= 2'b11;
            rdata_q <= '0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_axil_ram_master.sv
// tb/tb_axil_ram_master.sv - randomized self-checking bench for axil_ram_master against a RAM slave stub
module tb_axil_ram_master;
   localparam int DW  = 32;
   localparam int AW  = 16;
   localparam int SW  = 4;
   localparam int TMO = 16;

   logic          a_clk = 1'b0;
   logic          a_rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic [2:0]    cmd_prot = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          busy;

   int vectors = 0;
   int miscompares = 0;

   axil_ram_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) m_axil ();

   axil_ram_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .a_clk(a_clk), .a_rst(a_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
      .m_axil(m_axil)
   );

   always #5 a_clk = ~a_clk;

   // Slave stub: each ready rises after a programmable number of valid cycles, B/R are registered
   int            aw_dly = 0, w_dly = 0, ar_dly = 0;
   logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int            aw_cnt, w_cnt, ar_cnt;
   logic          got_aw, got_w;
   logic [DW-1:0] s_mem [256];

   initial for (int i = 0; i < 256; i++) s_mem[i] = '0;

   always_comb begin
      m_axil.awready = m_axil.awvalid && (aw_cnt >= aw_dly);
      m_axil.wready  = m_axil.wvalid && (w_cnt >= w_dly);
      m_axil.arready = m_axil.arvalid && (ar_cnt >= ar_dly);
   end

   always @(posedge a_clk or negedge a_rst) begin : slave
      logic aw_ok, w_ok;
      if (!a_rst) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         got_aw <= 1'b0; got_w <= 1'b0;
         m_axil.bvalid <= 1'b0; m_axil.bresp <= 2'b00;
         m_axil.rvalid <= 1'b0; m_axil.rresp <= 2'b00; m_axil.rdata <= '0;
      end else begin
         aw_cnt <= (m_axil.awvalid && !m_axil.awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (m_axil.wvalid && !m_axil.wready) ? w_cnt + 1 : 0;
         ar_cnt <= (m_axil.arvalid && !m_axil.arready) ? ar_cnt + 1 : 0;
         aw_ok = got_aw || (m_axil.awvalid && m_axil.awready);
         w_ok  = got_w || (m_axil.wvalid && m_axil.wready);
         if (m_axil.bvalid && m_axil.bready) m_axil.bvalid <= 1'b0;
         if (aw_ok && w_ok) begin
            for (int b = 0; b < SW; b++)
               if (m_axil.wstrb[b]) s_mem[int'(m_axil.awaddr[9:2])][8*b +: 8] <= m_axil.wdata[8*b +: 8];
            got_aw <= 1'b0; got_w <= 1'b0;
            m_axil.bvalid <= 1'b1; m_axil.bresp <= bresp_cfg;
         end else begin
            got_aw <= aw_ok; got_w <= w_ok;
         end
         if (m_axil.rvalid && m_axil.rready) m_axil.rvalid <= 1'b0;
         if (m_axil.arvalid && m_axil.arready) begin
            m_axil.rvalid <= 1'b1;
            m_axil.rdata  <= s_mem[int'(m_axil.araddr[9:2])];
            m_axil.rresp  <= rresp_cfg;
         end
      end
   end

   // Running totals of bus activity; tests take differences around a transaction
   int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs = 0, rsp_hs = 0, early_bready = 0;
   always @(negedge a_clk) begin
      if (m_axil.awvalid) aw_cyc++;
      if (m_axil.wvalid) w_cyc++;
      if (m_axil.arvalid) ar_cyc++;
      if (m_axil.bvalid && m_axil.bready) b_hs++;
      if (rsp_valid && rsp_ready) rsp_hs++;
      if (m_axil.bready && (m_axil.awvalid || m_axil.wvalid)) early_bready++;
   end

   logic [DW-1:0] ref_mem [16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one command, returns the response and the cycle count from accept edge to rsp_valid
   task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p,
                          output logic [DW-1:0] rd, output logic [1:0] rr, output logic rw,
                          output int lat, output logic [AW-1:0] o_addr, output logic [DW-1:0] o_wdata,
                          output logic [2:0] o_prot, output logic ok);
      int n;
      ok = 1'b1; lat = 0; rd = 'x; rr = 'x; rw = 'x; o_addr = 'x; o_wdata = 'x; o_prot = 'x;
      @(negedge a_clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge a_clk); n++; end
      if (!cmd_ready) begin ok = 1'b0; cmd_valid = 1'b0; return; end
      @(posedge a_clk);
      lat = 1;
      @(negedge a_clk);
      cmd_valid = 1'b0;
      o_addr  = w ? m_axil.awaddr : m_axil.araddr;
      o_prot  = w ? m_axil.awprot : m_axil.arprot;
      o_wdata = m_axil.wdata;
      while (!rsp_valid && lat < 200) begin @(posedge a_clk); lat++; @(negedge a_clk); end
      if (!rsp_valid) begin ok = 1'b0; return; end
      rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
      rsp_ready = 1'b1;
      @(posedge a_clk);
      @(negedge a_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] idle_bits;
      repeat (2) @(negedge a_clk);
      vectors++;
      if ({cmd_ready, busy, rsp_valid, m_axil.awvalid, m_axil.wvalid, m_axil.bready,
           m_axil.arvalid, m_axil.rready} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000000", {cmd_ready, busy, rsp_valid, m_axil.awvalid,
                  m_axil.wvalid, m_axil.bready, m_axil.arvalid, m_axil.rready});
      end
      vectors++;
      if ({rsp_write, rsp_resp, rsp_rdata, m_axil.awaddr, m_axil.wdata, m_axil.wstrb, m_axil.awprot,
           m_axil.araddr, m_axil.arprot} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got rdata %h resp %b awaddr %h wdata %h want all zero",
                  rsp_rdata, rsp_resp, m_axil.awaddr, m_axil.wdata);
      end
      a_rst = 1'b1;
      @(negedge a_clk);
      idle_bits = {30'd0, cmd_ready, busy};
      vectors++;
      if (idle_bits !== 32'd2) begin
         miscompares++;
         $display("FAIL idle_after_reset: got cmd_ready/busy %b want 10", idle_bits[1:0]);
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] rd, ow; logic [1:0] rr; logic rw, ok; int lat, ar0; logic [AW-1:0] oa; logic [2:0] op;
      run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'd2, rd, rr, rw, lat, oa, ow, op, ok);
      ref_mem[4] = 32'hDEADBEEF;
      vectors++;
      if (!ok || oa !== 16'h0010 || ow !== 32'hDEADBEEF || op !== 3'd2) begin
         miscompares++;
         $display("FAIL wr_bus: ok %b awaddr %h wdata %h prot %0d want 1 0010 deadbeef 2", ok, oa, ow, op);
      end
      vectors++;
      if (lat !== 3 || rr !== 2'b00 || rw !== 1'b1 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL wr_rsp: lat %0d resp %b write %b rdata %h want 3 00 1 00000000", lat, rr, rw, rd);
      end
      ar0 = ar_cyc;
      run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 3'd5, rd, rr, rw, lat, oa, ow, op, ok);
      vectors++;
      if (!ok || rd !== ref_mem[4] || rr !== 2'b00 || rw !== 1'b0 || lat !== 3 || op !== 3'd5) begin
         miscompares++;
         $display("FAIL rd_rsp: ok %b rdata %h resp %b write %b lat %0d prot %0d want 1 %h 00 0 3 5",
                  ok, rd, rr, rw, lat, op, ref_mem[4]);
      end
      vectors++;
      if (ar_cyc - ar0 !== 1) begin
         miscompares++;
         $display("FAIL arvalid_cycles: got %0d want 1", ar_cyc - ar0);
      end
   endtask

   task automatic test_aw_delay();
      logic [DW-1:0] rd, ow, d; logic [1:0] rr; logic rw, ok; int lat, aw0, w0, b0, r0, e0;
      logic [AW-1:0] oa; logic [2:0] op;
      d = $urandom;
      aw_dly = 4; w_dly = 0;
      aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs; r0 = rsp_hs; e0 = early_bready;
      run_txn(1'b1, 16'h0014, d, 4'hF, 3'd0, rd, rr, rw, lat, oa, ow, op, ok);
      ref_mem[5] = d;
      aw_dly = 0;
      vectors++;
      if (!ok || aw_cyc - aw0 !== 5 || w_cyc - w0 !== 1) begin
         miscompares++;
         $display("FAIL aw_delay_valids: ok %b awvalid %0d wvalid %0d want 1 5 1", ok, aw_cyc - aw0, w_cyc - w0);
      end
      vectors++;
      if (early_bready - e0 !== 0 || b_hs - b0 !== 1 || rsp_hs - r0 !== 1 || lat !== 7) begin
         miscompares++;
         $display("FAIL aw_delay_resp: early_bready %0d b_hs %0d rsp_hs %0d lat %0d want 0 1 1 7",
                  early_bready - e0, b_hs - b0, rsp_hs - r0, lat);
      end
   endtask

   task automatic test_backpressure();
      int n, bad;
      logic [DW-1:0] rd0;
      @(negedge a_clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0014; cmd_prot = 3'd0;
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge a_clk); n++; end
      vectors++;
      if (!rsp_valid) begin
         miscompares++;
         $display("FAIL bp_rsp_timeout: rsp_valid %b want 1", rsp_valid);
      end
      rd0 = rsp_rdata;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge a_clk);
         if (!rsp_valid || rsp_rdata !== rd0 || rsp_resp !== 2'b00 || cmd_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0 || rd0 !== ref_mem[5]) begin
         miscompares++;
         $display("FAIL bp_stable: unstable cycles %0d rdata %h want 0 %h", bad, rd0, ref_mem[5]);
      end
      rsp_ready = 1'b1;
      @(posedge a_clk);
      @(negedge a_clk);
      rsp_ready = 1'b0;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_ready_after_rsp: cmd_ready %b want 1", cmd_ready);
      end
      @(posedge a_clk);
      @(negedge a_clk);
      cmd_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || m_axil.arvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_next_accept: busy %b arvalid %b want 1 1", busy, m_axil.arvalid);
      end
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge a_clk); n++; end
      rsp_ready = 1'b1;
      @(posedge a_clk);
      @(negedge a_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_error_resp();
      logic [DW-1:0] rd, ow; logic [1:0] rr; logic rw, ok; int lat; logic [AW-1:0] oa; logic [2:0] op;
      rresp_cfg = 2'b10;
      run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, rd, rr, rw, lat, oa, ow, op, ok);
      rresp_cfg = 2'b00;
      vectors++;
      if (!ok || rr !== 2'b10 || rd !== ref_mem[4]) begin
         miscompares++;
         $display("FAIL slverr_read: ok %b resp %b rdata %h want 1 10 %h", ok, rr, rd, ref_mem[4]);
      end
      bresp_cfg = 2'b11;
      run_txn(1'b1, 16'h001C, 32'h1234_5678, 4'h3, 3'd0, rd, rr, rw, lat, oa, ow, op, ok);
      ref_mem[7][15:0] = 16'h5678;
      bresp_cfg = 2'b00;
      vectors++;
      if (!ok || rr !== 2'b11 || rd !== 32'h0 || rw !== 1'b1) begin
         miscompares++;
         $display("FAIL decerr_write: ok %b resp %b rdata %h write %b want 1 11 00000000 1", ok, rr, rd, rw);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd, ow, d; logic [1:0] rr; logic rw, ok; int lat, n; logic [AW-1:0] oa; logic [2:0] op;
      @(negedge a_clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_wdata = 32'hA5A5_5A5A;
      cmd_wstrb = 4'hF; cmd_prot = 3'd7;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge a_clk); n++; end
      @(posedge a_clk);
      @(negedge a_clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!m_axil.bready && n < 100) begin @(negedge a_clk); n++; end
      vectors++;
      if (m_axil.bready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_reach_wresp: bready %b want 1", m_axil.bready);
      end
      a_rst = 1'b0;
      #1;
      vectors++;
      if ({cmd_ready, busy, rsp_valid, m_axil.awvalid, m_axil.wvalid, m_axil.bready, m_axil.arvalid,
           m_axil.rready, rsp_write, rsp_resp, rsp_rdata, m_axil.awaddr, m_axil.wdata, m_axil.awprot} !== '0) begin
         miscompares++;
         $display("FAIL midrst_outputs: busy %b bready %b awaddr %h wdata %h prot %0d want all zero",
                  busy, m_axil.bready, m_axil.awaddr, m_axil.wdata, m_axil.awprot);
      end
      @(negedge a_clk);
      a_rst = 1'b1;
      d = $urandom;
      run_txn(1'b1, 16'h0018, d, 4'hF, 3'd1, rd, rr, rw, lat, oa, ow, op, ok);
      ref_mem[6] = d;
      vectors++;
      if (!ok || rr !== 2'b00 || lat !== 3 || oa !== 16'h0018 || ow !== d) begin
         miscompares++;
         $display("FAIL midrst_fresh_write: ok %b resp %b lat %0d awaddr %h wdata %h want 1 00 3 0018 %h",
                  ok, rr, lat, oa, ow, d);
      end
      run_txn(1'b0, 16'h0018, 32'h0, 4'h0, 3'd0, rd, rr, rw, lat, oa, ow, op, ok);
      vectors++;
      if (!ok || rd !== d || rr !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_readback: ok %b rdata %h resp %b want 1 %h 00", ok, rd, rr, d);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd, ow, d, exp_rd; logic [1:0] rr, resp; logic rw, ok, w; int lat, exp_lat, idx;
      logic [AW-1:0] oa, a; logic [2:0] op, p; logic [SW-1:0] s;
      for (int t = 0; t < 24; t++) begin
         w = 1'(($urandom % 2));
         idx = $urandom_range(0, 15);
         a = AW'(idx * 4);
         d = $urandom;
         s = SW'($urandom_range(1, 15));
         p = 3'($urandom_range(0, 7));
         resp = 2'($urandom_range(0, 3));
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         bresp_cfg = resp; rresp_cfg = resp;
         if (w) begin
            exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3;
            exp_rd = '0;
            for (int b = 0; b < SW; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            exp_lat = ar_dly + 3;
            exp_rd = ref_mem[idx];
         end
         run_txn(w, a, d, s, p, rd, rr, rw, lat, oa, ow, op, ok);
         vectors++;
         if (!ok || rd !== exp_rd || rr !== resp || rw !== w || lat !== exp_lat || oa !== a || op !== p) begin
            miscompares++;
            $display("FAIL random[%0d]: ok %b w %b rdata %h resp %b lat %0d addr %h prot %0d want rdata %h resp %b lat %0d addr %h prot %0d",
                     t, ok, rw, rd, rr, lat, oa, op, exp_rd, resp, exp_lat, a, p);
         end
      end
      aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
   endtask

`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      logic [DW-1:0] rd, ow; logic [1:0] rr; logic rw, ok; int lat; logic [AW-1:0] oa; logic [2:0] op;
      aw_dly = 1000;
      run_txn(1'b1, 16'h0020, 32'hCAFE_F00D, 4'hF, 3'd0, rd, rr, rw, lat, oa, ow, op, ok);
      vectors++;
      if (!ok || rr !== 2'b11 || rd !== 32'h0 || lat !== TMO + 1 || m_axil.awvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout: ok %b resp %b rdata %h lat %0d awvalid %b want 1 11 00000000 %0d 0",
                  ok, rr, rd, lat, m_axil.awvalid, TMO + 1);
      end
      aw_dly = 0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      test_reset();
      test_write_read();
      test_aw_delay();
      test_backpressure();
      test_error_resp();
      test_reset_mid();
      test_random();
`ifdef AXIL_RAM_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge a_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axil_ram_master.md
Name: axil_ram_master

Overview:
- Single-port AXI4-Lite initiator that drives one slave port (A or B) of the AXI-Lite dual-port RAM.
- Converts a simple valid/ready command request into a compliant AXI-Lite write or read transaction.
- Returns the outcome on a valid/ready response channel.
- Used as the bus-side stimulus/bring-up master and as the building block for the port-B traffic generator.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 16, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles per transaction; used only with AXIL_RAM_MASTER_TIMEOUT_EN

Ports:
- a_clk  in  1  clock; all logic on its rising edge
- a_rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  STRB_WIDTH  write byte enables
- cmd_prot  in  3  AxPROT value for both channels
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- busy  out  1  high in any state other than IDLE
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  AW channel
- m_axil_awready  in  1  AW channel
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  W channel
- m_axil_wready  in  1  W channel
- m_axil_bresp  in  2  B channel
- m_axil_bvalid  in  1  B channel
- m_axil_bready  out  1  B channel
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  AR channel
- m_axil_arready  in  1  AR channel
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  R channel
- m_axil_rready  out  1  R channel

Behaviour:
- Reset (a_rst = 0, asynchronous): state IDLE; all valid and ready outputs 0; cmd_ready 0 while in reset; rsp_rdata, rsp_resp, rsp_write and all m_axil address, data, strobe and prot outputs 0.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, wdata, wstrb and prot.
  - Write: go to WRITE with awvalid = wvalid = 1 on the next cycle.
  - Read: go to READ with arvalid = 1 on the next cycle.
- WRITE:
  - awvalid drops the cycle after awvalid && awready; wvalid drops the cycle after wvalid && wready. The two handshakes are independent and either order or the same cycle is legal.
  - Move to WRESP once both have completed.
  - Payload stays stable while its valid is high.
- WRESP: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0, go to RSP.
- READ: arvalid held until arready, then go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata and rresp, go to RSP.
- RSP: rsp_valid = 1, outputs stable. On rsp_ready, go to IDLE.
- One outstanding transaction only. cmd_ready = 0 outside IDLE, so the next command is accepted the cycle after the response handshake.
- Best-case latency with a zero-wait slave:
  - write: accept → AW/W 1 cycle → B 1 cycle → rsp_valid at cycle 3
  - read: accept → AR 1 cycle → R 1 cycle → rsp_valid at cycle 3
- rsp_resp passes SLVERR/DECERR through unchanged; no retry.
- Reset mid-transaction aborts immediately: all valids drop and FSM returns to IDLE. The slave is reset on the same a_rst.
- bvalid or rvalid asserted outside WRESP/RDATA is ignored; ready stays 0.

Optional Feature:
- Macro AXIL_RAM_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WRITE or READ and increments each cycle in WRITE, WRESP, READ and RDATA.
  - When the count reaches TIMEOUT_CYCLES-1 without completion, all m_axil valid and ready outputs drop and the FSM goes to RSP with rsp_resp = 2'b11 and rsp_rdata = 0.
  - This is a recovery-only protocol violation.
- When undefined: no counter; the FSM waits indefinitely and TIMEOUT_CYCLES is ignored.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, wstrb 0xF, zero-wait slave → awaddr = 0x0010, wdata = 0xDEADBEEF; rsp_valid 3 cycles after accept with rsp_resp = 0, rsp_write = 1.
- Read addr 0x0010 after the write above → rsp_rdata = 0xDEADBEEF, rsp_resp = 0, rsp_write = 0; arvalid high exactly 1 cycle.
- Write with awready delayed 4 cycles and wready immediate → wvalid high 1 cycle, awvalid high 5 cycles, bready asserted only after both; single response.
- rsp_ready held 0 for 10 cycles with cmd_valid = 1 → rsp_valid and data stable; cmd_ready = 0 throughout; next command accepted 1 cycle after rsp_ready = 1.
- Slave returns RRESP = 2'b10 → rsp_resp = 2'b10 with rdata passed through.
- Assert a_rst = 0 during WRESP → all outputs 0 asynchronously; after release, a fresh write completes normally. With AXIL_RAM_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 16 and awready never asserted → rsp_resp = 2'b11 after 16 cycles.
